// File: rtl/rs232_pkg.sv
// Shared types and constants for the RS-232 transmit arbiter.
package rs232_pkg;

    // Payload bits per frame and stop bits appended after data/parity.
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned STOP_BITS = 1;

    // Framing states; PARITY is only reachable when parity is compiled in.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    // Clock cycles per bit, truncating.
    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/rs232_rr_arbiter.sv
// Combinational round-robin pick: first valid requester after the last grant.
module rs232_rr_arbiter
    import rs232_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         valid_i,
    input  logic [$clog2(NUM_REQ)-1:0] last_i,
    output logic [NUM_REQ-1:0]         onehot_c_o,
    output logic [$clog2(NUM_REQ)-1:0] idx_c_o
);

    localparam int unsigned IW = $clog2(NUM_REQ);

    logic          found;
    logic [IW-1:0] cand;

    // Scan (last+1) .. (last+NUM_REQ) modulo NUM_REQ; the first hit wins.
    always_comb begin
        onehot_c_o = '0;
        idx_c_o    = '0;
        found      = 1'b0;
        cand       = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            cand = IW'((32'(last_i) + off) % NUM_REQ);
            if (!found && valid_i[cand]) begin
                found            = 1'b1;
                onehot_c_o[cand] = 1'b1;
                idx_c_o          = cand;
            end
        end
    end

endmodule

// File: rtl/rs232_tx_arbiter.sv
// Round-robin shared RS-232 transmitter, LSB-first framing at BAUD.
// Define RS232_PARITY_EN to insert an even-parity bit (8E1); default is 8N1.
module rs232_tx_arbiter
    import rs232_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 1000000,
    parameter int unsigned BAUD    = 9600,
    parameter int unsigned NUM_REQ = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NUM_REQ-1:0]           req_valid_i,
    input  logic [8*NUM_REQ-1:0]         req_data_i,
    output logic [NUM_REQ-1:0]           req_ready_o,
    output logic [$clog2(NUM_REQ)-1:0]   grant_o,
    output logic                         busy_o,
    output logic                         TXD_o
);

    localparam int unsigned DIV = calc_div(CLK_HZ, BAUD);
    localparam int unsigned IW  = $clog2(NUM_REQ);
    localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned BW  = $clog2(DATA_W);

    tx_state_e           state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [BW-1:0]       bit_q, bit_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [IW-1:0]       grant_q, grant_d;
    logic                busy_q, busy_d;
    logic [NUM_REQ-1:0]  ready_q, ready_d;
    logic                txd_q, txd_d;
`ifdef RS232_PARITY_EN
    logic                parity_q, parity_d;
`endif

    logic [DATA_W-1:0]   req_bytes [NUM_REQ];
    logic [NUM_REQ-1:0]  win_onehot;
    logic [IW-1:0]       win_idx;
    logic [DATA_W-1:0]   win_data;
    logic                bit_end;

    // Split the flat data bus into one byte per requester.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
        assign req_bytes[g] = req_data_i[g*DATA_W +: DATA_W];
    end

    rs232_rr_arbiter #(
        .NUM_REQ    (NUM_REQ)
    ) u_arb (
        .valid_i    (req_valid_i),
        .last_i     (grant_q),
        .onehot_c_o (win_onehot),
        .idx_c_o    (win_idx)
    );

    assign win_data = req_bytes[win_idx];
    assign bit_end  = (cnt_q == CW'(DIV - 1));

    // Next-state, counters, shifter and the registered line value.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        grant_d  = grant_q;
        busy_d   = busy_q;
        ready_d  = '0;
        txd_d    = 1'b1;
`ifdef RS232_PARITY_EN
        parity_d = parity_q;
`endif

        // Baud counter free-runs 0..DIV-1 whenever a frame is in flight.
        if (state_q != IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + CW'(1);
        end

        case (state_q)
            IDLE: begin
                if (|req_valid_i) begin
                    state_d  = START;
                    shift_d  = win_data;
                    grant_d  = win_idx;
                    busy_d   = 1'b1;
                    cnt_d    = '0;
                    bit_d    = '0;
                    ready_d  = win_onehot;
`ifdef RS232_PARITY_EN
                    parity_d = ^win_data;
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == BW'(DATA_W - 1)) begin
                        bit_d = '0;
`ifdef RS232_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
`ifdef RS232_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    if (bit_q == BW'(STOP_BITS - 1)) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Line level follows the state being entered so TXD_o lines up with it.
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
`ifdef RS232_PARITY_EN
            PARITY:  txd_d = parity_d;
`endif
            default: txd_d = 1'b1;
        endcase
    end

    // State and datapath registers; reset forces the line idle-high at once.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            grant_q  <= IW'(NUM_REQ - 1);
            busy_q   <= 1'b0;
            ready_q  <= '0;
            txd_q    <= 1'b1;
`ifdef RS232_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            grant_q  <= grant_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
            txd_q    <= txd_d;
`ifdef RS232_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign req_ready_o = ready_q;
    assign grant_o     = grant_q;
    assign busy_o      = busy_q;
    assign TXD_o       = txd_q;

endmodule

// File: tb/tb_rs232_tx_arbiter.sv
// Self-checking bench for rs232_tx_arbiter (DIV=10, two requesters).
// Honors RS232_PARITY_EN for frame length and the parity scenario.
module tb_rs232_tx_arbiter;

    localparam int CLK_HZ  = 96000;
    localparam int BAUD    = 9600;
    localparam int NUM_REQ = 2;
    localparam int DIV     = 10;
`ifdef RS232_PARITY_EN
    localparam int FL = 11 * DIV;
`else
    localparam int FL = 10 * DIV;
`endif

    logic        clk;
    logic        rst_i;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_ready;
    logic [0:0]  grant;
    logic        busy;
    logic        txd;

    rs232_tx_arbiter #(
        .CLK_HZ  (CLK_HZ),
        .BAUD    (BAUD),
        .NUM_REQ (NUM_REQ)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_ready_o (req_ready),
        .grant_o     (grant),
        .busy_o      (busy),
        .TXD_o       (txd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: frame position counted in cycles since the first START cycle.
    bit         m_busy;
    int         m_off;
    int         m_grant;
    logic [7:0] m_byte;
    logic [1:0] m_ready;
    int         m_w;
    int         m_idx;

    always @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            m_busy  = 1'b0;
            m_off   = 0;
            m_grant = NUM_REQ - 1;
            m_ready = 2'b00;
            m_byte  = 8'h00;
        end else begin
            m_ready = 2'b00;
            if (m_busy) begin
                m_off++;
                if (m_off == FL) m_busy = 1'b0;
            end else begin
                m_w = -1;
                for (int k = 1; k <= NUM_REQ; k++) begin
                    m_idx = (m_grant + k) % NUM_REQ;
                    if (m_w < 0 && req_valid[m_idx]) m_w = m_idx;
                end
                if (m_w >= 0) begin
                    m_grant     = m_w;
                    m_byte      = 8'(req_data >> (8 * m_w));
                    m_busy      = 1'b1;
                    m_off       = 0;
                    m_ready[m_w] = 1'b1;
                end
            end
        end
    end

    function automatic int exp_txd();
        int slot;
        if (!m_busy) return 1;
        slot = m_off / DIV;
        if (slot == 0) return 0;
        if (slot <= 8) return int'(m_byte[slot-1]);
`ifdef RS232_PARITY_EN
        if (slot == 9) return int'(^m_byte);
`endif
        return 1;
    endfunction

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("txd",   int'(txd),       exp_txd());
            check("busy",  int'(busy),      int'(m_busy));
            check("ready", int'(req_ready), int'(m_ready));
            check("grant", int'(grant),     m_grant);
        end
    end

    // Run-length monitor for busy/idle spans and ready pulses of requester 1.
    int cyc = 0, run = 0, last_run = 0, gap_run = 0, last_gap = 0, r1_cnt = 0;
    always @(negedge clk) begin
        cyc++;
        if (busy) begin
            run++;
            if (gap_run != 0) begin last_gap = gap_run; gap_run = 0; end
        end else begin
            gap_run++;
            if (run != 0) begin last_run = run; run = 0; end
        end
        if (req_ready[1]) r1_cnt++;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ready(input int bound, output logic [1:0] r);
        r = 2'b00;
        for (int i = 0; i < bound; i++) begin
            step();
            if (req_ready != 2'b00) begin
                r = req_ready;
                break;
            end
        end
        if (r == 2'b00) check("ready_timeout", 0, 1);
    endtask

    task automatic wait_idle(input int bound);
        bit done;
        done = 1'b0;
        for (int i = 0; i < bound; i++) begin
            step();
            if (!busy) begin done = 1'b1; break; end
        end
        if (!done) check("idle_timeout", 0, 1);
    endtask

    task automatic set_byte(input int k, input logic [7:0] b);
        req_data = (req_data & ~(16'hFF << (8 * k))) | (16'(b) << (8 * k));
    endtask

    task automatic do_reset();
        step();
        rst_i = 1'b0;
        repeat (2) step();
        check("rst_txd",   int'(txd),       1);
        check("rst_busy",  int'(busy),      0);
        check("rst_ready", int'(req_ready), 0);
        check("rst_grant", int'(grant),     1);
        step();
        rst_i = 1'b1;
    endtask

    logic [1:0] r;
    logic [9:0] single_exp;
    int c0;

    initial begin
        #400000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_i     = 1'b1;
        req_valid = 2'b00;
        req_data  = 16'h0000;
        #1 rst_i  = 1'b0;
        #1 cmp_en = 1'b1;
        repeat (2) step();
        check("init_txd",   int'(txd),       1);
        check("init_busy",  int'(busy),      0);
        check("init_ready", int'(req_ready), 0);
        check("init_grant", int'(grant),     1);
        rst_i = 1'b1;

        // Single byte 0xA5 from requester 0.
`ifdef RS232_PARITY_EN
        single_exp = {1'b0, 8'hA5, 1'b0};
`else
        single_exp = {1'b1, 8'hA5, 1'b0};
`endif
        req_data  = 16'h00A5;
        req_valid = 2'b01;
        wait_ready(50, r);
        check("single_ready", int'(r), 1);
        check("single_grant", int'(grant), 0);
        req_valid = 2'b00;
        step();
        check("single_ready_pulse", int'(req_ready), 0);
        repeat (4) step();
        for (int b = 0; b < 10; b++) begin
            check("single_bit", int'(txd), int'(single_exp[b]));
            if (b < 9) repeat (10) step();
        end
        wait_idle(200);
        check("single_busy_len", last_run, FL);

        // Contention from reset: strict alternation starting at requester 0.
        do_reset();
        req_data  = 16'h2211;
        req_valid = 2'b11;
        c0 = 0;
        for (int f = 0; f < 4; f++) begin
            wait_ready(300, r);
            check("cont_ready", int'(r), (f % 2 == 0) ? 1 : 2);
            check("cont_grant", int'(grant), f % 2);
            if (f > 0) check("cont_spacing", cyc - c0, FL + 1);
            if (f == 1) check("cont_gap", last_gap, 1);
            c0 = cyc;
        end
        req_valid = 2'b00;
        wait_idle(200);

        // Request while busy waits for the IDLE cycle after STOP.
        req_data  = 16'h3C5A;
        req_valid = 2'b01;
        wait_ready(50, r);
        check("busyreq_first", int'(r), 1);
        req_valid = 2'b00;
        c0 = cyc;
        repeat (30) step();
        req_valid[1] = 1'b1;
        wait_ready(200, r);
        check("busyreq_ready", int'(r), 2);
        check("busyreq_delay", cyc - c0, FL + 1);
        req_valid = 2'b00;
        wait_idle(200);

        // Reset 45 cycles into a frame.
        req_data  = 16'h00A5;
        req_valid = 2'b01;
        wait_ready(50, r);
        req_valid = 2'b00;
        repeat (45) step();
        check("prereset_txd", int'(txd), 0);
        #1 rst_i = 1'b0;
        #1;
        check("midreset_txd",  int'(txd),  1);
        check("midreset_busy", int'(busy), 0);
        repeat (2) step();
        rst_i     = 1'b1;
        req_data  = 16'h6677;
        req_valid = 2'b11;
        wait_ready(50, r);
        check("postreset_first", int'(r), 1);
        req_valid = 2'b00;
        wait_idle(200);

        // Withdrawn request while busy is never granted.
        req_data  = 16'h99C3;
        req_valid = 2'b01;
        wait_ready(50, r);
        req_valid = 2'b00;
        c0 = r1_cnt;
        repeat (20) step();
        req_valid[1] = 1'b1;
        repeat (3) step();
        req_valid[1] = 1'b0;
        repeat (250) step();
        check("withdraw_grants", r1_cnt - c0, 0);
        check("withdraw_txd",    int'(txd),  1);
        check("withdraw_busy",   int'(busy), 0);

`ifdef RS232_PARITY_EN
        // Even parity of 0x07 is 1; stop bit from offset 100; 110-cycle frame.
        req_data  = 16'h0007;
        req_valid = 2'b01;
        wait_ready(50, r);
        req_valid = 2'b00;
        repeat (85) step();
        check("par_bit7", int'(txd), 0);
        repeat (10) step();
        check("par_bit", int'(txd), 1);
        repeat (5) step();
        check("par_stop_txd",  int'(txd),  1);
        check("par_stop_busy", int'(busy), 1);
        wait_idle(200);
        check("par_len", last_run, 110);
`endif

        // Randomized requesters honoring the hold-until-ready protocol.
        for (int i = 0; i < 4000; i++) begin
            step();
            for (int k = 0; k < NUM_REQ; k++) begin
                if (req_valid[k] && req_ready[k]) begin
                    req_valid[k] = 1'b0;
                end else if (!req_valid[k]) begin
                    if ($urandom_range(0, 99) < 6) begin
                        set_byte(k, 8'($urandom));
                        req_valid[k] = 1'b1;
                    end
                end else if ($urandom_range(0, 999) < 4) begin
                    req_valid[k] = 1'b0;
                end
            end
        end
        req_valid = 2'b00;
        wait_idle(300);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rs232_tx_arbiter.md
Name: rs232_tx_arbiter

Overview:
- Shares one RS-232 8N1 transmit line between NUM_REQ byte requesters.
- Round-robin arbitration, valid/ready handshake per requester.
- Internal baud divider, so no separate baud clock is needed.
- Sits between the command/response producers and the TXD pin. Frames go out LSB-first at BAUD.

Parameters:
- CLK_HZ, 1000000, system clock frequency in Hz.
- BAUD, 9600, line bit rate.
- NUM_REQ, 2, number of requesters (2..8).
- DIV, CLK_HZ/BAUD (integer divide, truncating), clock cycles per bit. Derived; do not override.

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_i  in  1  asynchronous reset, active-low (rst_i==0 resets).
- req_valid_i  in  NUM_REQ  requester k has a byte pending.
- req_data_i  in  8*NUM_REQ  byte for requester k at bits [8k+7:8k].
- req_ready_o  out  NUM_REQ  one-hot, one-cycle accept pulse.
- grant_o  out  $clog2(NUM_REQ)  index of the requester whose frame is in flight (last granted).
- busy_o  out  1  frame in progress.
- TXD_o  out  1  serial line, idle high.

Behaviour:
- Reset values: TXD_o=1, busy_o=0, req_ready_o=0, grant_o=NUM_REQ-1, state=IDLE, bit and baud counters 0. The round-robin pointer resets to NUM_REQ-1, so requester 0 wins first.
- States: IDLE, START, DATA, (PARITY), STOP.
- IDLE:
  - If any req_valid_i is set, select the first valid index scanning from (grant_o+1) mod NUM_REQ upward with wrap.
  - On that clock edge: latch req_data_i of the winner into the shift register, update grant_o, set busy_o=1, clear the baud counter, go to START.
  - req_ready_o[winner]=1 for exactly that one cycle. It is registered and visible in the cycle after the decision.
  - Requesters hold valid and data stable until they see ready. The byte is sampled at the decision edge only.
  - A requester that drops valid before being granted is simply skipped.
- Baud counter counts 0..DIV-1. The bit period ends when the count reaches DIV-1; the counter then wraps to 0.
- START: TXD_o=0 for DIV cycles, then go to DATA with bit index 0.
- DATA: TXD_o=shift[0]. At each bit-period end, shift right and increment the index. After index 7 completes, go to PARITY (if enabled) or STOP.
- STOP: TXD_o=1 for DIV cycles. Then busy_o=0 and go to IDLE.
- Frame length: exactly 10*DIV cycles from the first START cycle to the last STOP cycle (11*DIV with parity).
- Back-to-back frames: IDLE lasts one cycle, so the minimum inter-frame gap is 1 clock of idle-high.
- Requests arriving while busy are not acknowledged. They are arbitrated at the next IDLE.
- Simultaneous requests: the round-robin scan decides. Two requesters held valid alternate strictly.
- Reset mid-frame: TXD_o returns to 1 immediately (asynchronously) and the frame is abandoned. No ready pulse is re-issued.
- grant_o holds its value while IDLE.

Optional Feature:
- RS232_PARITY_EN defined:
  - A PARITY state follows DATA.
  - TXD_o = XOR of the 8 latched data bits (even parity) for DIV cycles.
  - Frame is 11*DIV cycles.
- RS232_PARITY_EN undefined: no PARITY state, no parity logic, 8N1 framing.

Decomposition:
- Shared package rs232_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - the data-width constant 8;
  - the stop-bit count 1;
  - a function computing DIV from CLK_HZ and BAUD.
- One sub-module, rs232_rr_arbiter: combinational round-robin priority pick given the valid vector and the last grant. It outputs the one-hot winner and its index.
- Framing FSM, baud counter and shifter stay in rs232_tx_arbiter.

Test Plan:
All scenarios use CLK_HZ=96000, BAUD=9600 (DIV=10) and NUM_REQ=2.
- Single byte: req0 valid with 0xA5.
  - req_ready_o=01 for one cycle.
  - TXD_o = 0, then 1,0,1,0,0,1,0,1, then 1.
  - Each bit lasts 10 cycles; busy_o lasts 100 cycles.
- Contention: both valid continuously, req0=0x11 and req1=0x22.
  - Frames go out in the order 0x11, 0x22, 0x11, ...
  - grant_o alternates 0,1,0.
  - Idle gap between frames is exactly 1 cycle.
- Request while busy: req1 asserts 30 cycles into a req0 frame.
  - No ready until the frame ends.
  - req1 is granted in the IDLE cycle after STOP.
- Reset mid-frame: pull rst_i low at cycle 45 of a frame.
  - TXD_o=1 and busy_o=0 immediately.
  - After release, req0 wins first again.
- Withdrawn request: req1 pulses valid for 3 cycles while busy, then drops.
  - req1 is never granted; the line stays idle-high.
- With RS232_PARITY_EN defined, byte 0x07:
  - Parity bit is 1.
  - Frame is 110 cycles.
  - Stop bit starts at cycle 100.
